wb_slave_regfile: RTL and testbench
===================================

// Module: wb_slave_regfile
// PURPOSE
//  Wishbone B4 slave exposing NUM_REGS byte-selectable DATA_WIDTH registers at BASE_ADDR.
//  Adds to the single-register slave: configurable depth, wait states, out-of-range ERR,
//  and a PIPELINED mode with stall_o. Sits behind the interconnect as a generic CSR bank.
// PARAMETERS
//  ADDR_WIDTH   16  word-address width of adr_i
//  DATA_WIDTH   32  data bus width
//  GRANULE      8   byte-lane width; SEL_WIDTH = DATA_WIDTH/GRANULE
//  NUM_REGS     8   register count (>=1)
//  BASE_ADDR    0   word address of register 0
//  WAIT_STATES  0   extra cycles inserted before the response (0..15)
//  PIPELINED    0   0 = classic (stall_o tied 0), 1 = B4 pipelined handshake
//  WP_MASK      0   NUM_REGS-bit write-protect mask (used only with macro, see CONFIGURATION)
// PORTS
//  clk_i   in   1           clock
//  rst_i   in   1           reset; synchronous, active-high
//  cyc_i   in   1           bus cycle valid
//  stb_i   in   1           strobe
//  we_i    in   1           1 = write, 0 = read
//  adr_i   in   ADDR_WIDTH  word address
//  sel_i   in   SEL_WIDTH   byte-lane select
//  dat_i   in   DATA_WIDTH  write data
//  dat_o   out  DATA_WIDTH  read data; valid only while ack_o = 1, else 0
//  ack_o   out  1           normal termination, one-cycle pulse
//  err_o   out  1           error termination, one-cycle pulse; never together with ack_o
//  stall_o out  1           pipelined back-pressure (constant 0 when PIPELINED = 0)
// BEHAVIOUR
//  Reset: state IDLE; all registers, dat_o, ack_o, err_o, stall_o = 0. Reset mid-transfer
//   aborts it: no write, no response.
//  FSM IDLE -> WAIT -> RESP -> IDLE; WAIT is skipped when WAIT_STATES = 0.
//  IDLE: accept on cyc_i & stb_i (& !stall_o). Latch adr, sel, we, dat.
//   Go to WAIT (load counter = WAIT_STATES-1) or to RESP.
//  WAIT: decrement the counter; go to RESP when it reaches 0.
//  RESP: ack_o or err_o = 1 for exactly this cycle, then IDLE.
//   Latency: response WAIT_STATES+1 cycles after the accepting edge.
//  Decode: idx = latched_adr - BASE_ADDR (unsigned). idx >= NUM_REGS or adr < BASE_ADDR -> err_o,
//   no write, dat_o = 0.
//  Write: lanes with sel = 1 are replaced on the edge entering RESP. Other lanes are held.
//   sel = 0 still ACKs.
//  Read: dat_o = reg[idx] with unselected lanes forced to 0. A read in the next transfer sees
//   the previous write.
//  Pipelined: stall_o = (state != IDLE). The master may drop stb_i after acceptance.
//   Back-to-back requests are accepted only in IDLE. stall_o never gates an in-flight response.
//  Classic: the master holds stb_i until it sees ack/err. The slave re-enters IDLE on the edge
//   after RESP, so a held stb_i then starts a new transfer.
//  cyc_i = 0 in WAIT or RESP: abort. Return to IDLE next edge, suppress response; a write not
//   yet committed is dropped.
//  RMW (read then write within one cyc_i) = two independent transfers; no lock required.
// CONFIGURATION
//  WB_SLAVE_REGFILE_WP_EN defined: a write to idx with WP_MASK[idx] = 1 returns err_o
//   and leaves the register unchanged; reads are unaffected.
//  Not defined: WP_MASK is ignored; all in-range writes ACK.
// STRUCTURE
//  wb_pkg: state_t {IDLE, WAIT, RESP}, ret_t {RETURN_ACK, RETURN_ERR},
//   function sel_merge(old, new, sel) for byte-lane merging.
//  One sub-module: wb_wait_counter (load / decrement / zero flag, 4-bit), instantiated when
//   WAIT_STATES > 0.
//  Register array and FSM live in wb_slave_regfile.
// TESTING (bench drives classic and pipelined masters; NUM_REGS=8, BASE_ADDR=0x10)
//  1. Reset, classic read 0x0012 sel F -> ack_o, dat_o 0x00000000, 1-cycle latency.
//  2. Write 0x0013 sel F 0xDEADBEEF, then write sel 0x3 0x00001234, then read sel F
//     -> 0xDEAD1234.
//  3. Read 0x0018 and 0x000F -> err_o pulse, dat_o 0, no ack_o; write 0x0018 leaves all
//     registers unchanged.
//  4. WAIT_STATES=3, pipelined write 0x0011 0xCAFEF00D -> stall_o high 4 cycles,
//     ack_o 4 cycles after acceptance; readback OK.
//  5. Drop cyc_i during WAIT of a write to 0x0014 -> no ack/err; readback returns the
//     old value 0x00000000.
//  6. Macro on, WP_MASK=8'h04: write 0x0012 0xFFFFFFFF -> err_o, readback 0x00000000 with ACK.
//     Macro off: ACK, readback 0xFFFFFFFF.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and the byte-lane merge helper for the Wishbone register-file slave.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        RETURN_ACK = 1'b0,
        RETURN_ERR = 1'b1
    } ret_t;

    // Widest bus the merge helper supports; callers zero-extend into and truncate out of it.
    localparam int unsigned WB_MAX_DW = 256;
    localparam int unsigned WB_MAX_SW = 256;

    // Lanes whose sel bit is set take new_v, the rest keep old_v.
    function automatic logic [WB_MAX_DW-1:0] sel_merge(
        input logic [WB_MAX_DW-1:0] old_v,
        input logic [WB_MAX_DW-1:0] new_v,
        input logic [WB_MAX_SW-1:0] sel,
        input int unsigned          granule
    );
        logic [WB_MAX_DW-1:0] merged;
        logic [WB_MAX_SW-1:0] lanes;
        int unsigned          cnt;
        merged = '0;
        lanes  = sel;
        cnt    = 0;
        for (int b = 0; b < WB_MAX_DW; b++) begin
            merged[b] = lanes[0] ? new_v[b] : old_v[b];
            cnt++;
            if (cnt == granule) begin
                cnt   = 0;
                lanes = lanes >> 1;
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_wait_counter.sv
// 4-bit wait-state counter: load a start value, count down, flag zero.
module wb_wait_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       dec_i,
    input  logic [3:0] load_val_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 CSR bank: NUM_REGS byte-selectable registers with wait states, range ERR and
// optional pipelined handshake. Define WB_SLAVE_REGFILE_WP_EN to enable write protection via WP_MASK.
module wb_slave_regfile
    import wb_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH  = 16,
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          GRANULE     = 8,
    parameter int unsigned          NUM_REGS    = 8,
    parameter int unsigned          BASE_ADDR   = 0,
    parameter int unsigned          WAIT_STATES = 0,
    parameter int unsigned          PIPELINED   = 0,
    parameter logic [NUM_REGS-1:0]  WP_MASK     = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cyc_i,
    input  logic                             stb_i,
    input  logic                             we_i,
    input  logic [ADDR_WIDTH-1:0]            adr_i,
    input  logic [DATA_WIDTH/GRANULE-1:0]    sel_i,
    input  logic [DATA_WIDTH-1:0]            dat_i,
    output logic [DATA_WIDTH-1:0]            dat_o,
    output logic                             ack_o,
    output logic                             err_o,
    output logic                             stall_o
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE;
    localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

`ifdef WB_SLAVE_REGFILE_WP_EN
    localparam bit WP_ENABLED = 1'b1;
`else
    localparam bit WP_ENABLED = 1'b0;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;

    logic                    cnt_load, cnt_dec, cnt_zero;
    logic                    enter_resp;
    ret_t                    ret;
    logic [ADDR_WIDTH-1:0]   cur_adr, idx_full;
    logic [SEL_WIDTH-1:0]    cur_sel;
    logic                    cur_we;
    logic [DATA_WIDTH-1:0]   cur_dat;
    logic [IDX_W-1:0]        idx;
    logic                    in_range, wp_hit;
    logic [DATA_WIDTH-1:0]   write_merged, read_masked;

    generate
        if (WAIT_STATES > 0) begin : g_wait
            wb_wait_counter u_wait_counter (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .load_i     (cnt_load),
                .dec_i      (cnt_dec),
                .load_val_i (4'(WAIT_STATES - 1)),
                .zero_o     (cnt_zero)
            );
        end else begin : g_no_wait
            assign cnt_zero = 1'b1;
        end
    endgenerate

    // With no wait states the response is decided on the accepting edge itself,
    // so the transfer is described by the live bus rather than the latched copy.
    always_comb begin
        cur_adr  = (state_q == IDLE) ? adr_i : adr_q;
        cur_sel  = (state_q == IDLE) ? sel_i : sel_q;
        cur_we   = (state_q == IDLE) ? we_i  : we_q;
        cur_dat  = (state_q == IDLE) ? dat_i : wdat_q;
        idx_full = cur_adr - BASE;
        idx      = idx_full[IDX_W-1:0];
        in_range = (cur_adr >= BASE) && (idx_full < ADDR_WIDTH'(NUM_REGS));
        wp_hit   = WP_ENABLED && cur_we && WP_MASK[idx];
        write_merged = DATA_WIDTH'(sel_merge(WB_MAX_DW'(regs_q[idx]), WB_MAX_DW'(cur_dat),
                                             WB_MAX_SW'(cur_sel), GRANULE));
        read_masked  = DATA_WIDTH'(sel_merge('0, WB_MAX_DW'(regs_q[idx]),
                                             WB_MAX_SW'(cur_sel), GRANULE));
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        we_d       = we_q;
        wdat_d     = wdat_q;
        regs_d     = regs_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdat_d     = '0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        enter_resp = 1'b0;
        ret        = RETURN_ACK;

        case (state_q)
            IDLE: begin
                if (cyc_i && stb_i && !stall_o) begin
                    adr_d  = adr_i;
                    sel_d  = sel_i;
                    we_d   = we_i;
                    wdat_d = dat_i;
                    if (WAIT_STATES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d  = WAIT;
                        cnt_load = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The write commits on the same edge that registers the response.
        if (enter_resp) begin
            state_d = RESP;
            ret     = (!in_range || wp_hit) ? RETURN_ERR : RETURN_ACK;
            if (ret == RETURN_ERR) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (cur_we) begin
                    regs_d[idx] = write_merged;
                end else begin
                    rdat_d = read_masked;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            regs_q  <= regs_d;
        end
    end

    // Dropping cyc_i while in RESP withdraws the response that cycle.
    assign ack_o   = ack_q && cyc_i;
    assign err_o   = err_q && cyc_i;
    assign dat_o   = ack_o ? rdat_q : '0;
    assign stall_o = (PIPELINED != 0) && (state_q != IDLE);

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Randomized self-checking bench: a classic zero-wait slave and a pipelined 3-wait slave
// checked against an array-based model of the register bank.
module tb_wb_slave_regfile;

    localparam int NREG = 8;
    localparam int BASE = 16;
    localparam logic [7:0] WPM = 8'h04;
`ifdef WB_SLAVE_REGFILE_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cyc, stb, ack, err, stall;
    logic        we;
    logic [15:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat, rdat0, rdat1;

    always #5 clk = ~clk;

    wb_slave_regfile #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8), .NUM_REGS(NREG), .BASE_ADDR(BASE),
        .WAIT_STATES(0), .PIPELINED(0), .WP_MASK(WPM)
    ) u_dut_classic (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we), .adr_i(adr),
        .sel_i(sel), .dat_i(wdat), .dat_o(rdat0), .ack_o(ack[0]), .err_o(err[0]),
        .stall_o(stall[0])
    );

    wb_slave_regfile #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8), .NUM_REGS(NREG), .BASE_ADDR(BASE),
        .WAIT_STATES(3), .PIPELINED(1), .WP_MASK(WPM)
    ) u_dut_pipe (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we), .adr_i(adr),
        .sel_i(sel), .dat_i(wdat), .dat_o(rdat1), .ack_o(ack[1]), .err_o(err[1]),
        .stall_o(stall[1])
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mregs [2][NREG];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_rdat(input int d);
        return (d == 0) ? rdat0 : rdat1;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NREG; i++)
                mregs[d][i] = 32'h0;
    endtask

    // Response kind: 1 = ack only, 2 = err only, 3 = both, 0 = none.
    task automatic xfer(input int d, input logic w, input logic [15:0] a, input logic [3:0] s,
                        input logic [31:0] wd, output logic [31:0] rd_out);
        int          idx, exp_kind, kind, lat, stalls;
        logic [31:0] lanes, exp_data, seen;
        lanes    = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        idx      = int'(a) - BASE;
        exp_data = 32'h0;
        exp_kind = 1;
        if (idx < 0 || idx >= NREG) begin
            exp_kind = 2;
        end else if (w && WP_ON && WPM[idx]) begin
            exp_kind = 2;
        end else if (w) begin
            mregs[d][idx] = (mregs[d][idx] & ~lanes) | (wd & lanes);
        end else begin
            exp_data = mregs[d][idx] & lanes;
        end

        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we = w; adr = a; sel = s; wdat = wd;
        @(posedge clk);
        kind = 0; lat = 0; stalls = 0; seen = 32'h0;
        while (kind == 0 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (d == 1) stb[d] = 1'b0;
            if (stall[d]) stalls++;
            if (ack[d] || err[d]) begin
                kind = {30'd0, err[d], ack[d]};
                seen = dut_rdat(d);
            end
        end
        stb[d] = 1'b0;
        $display("xfer dut%0d %s adr=%04h sel=%h wd=%08h -> kind=%0d rd=%08h lat=%0d stalls=%0d",
                 d, w ? "WR" : "RD", a, s, wd, kind, seen, lat, stalls);
        check_val("resp_kind", kind, exp_kind);
        check_val("rdata", seen, exp_data);
        check_val("latency", lat, (d == 0) ? 1 : 4);
        check_val("stall_cycles", stalls, (d == 0) ? 0 : 4);
        @(negedge clk);
        check_val("pulse_end", {30'd0, err[d], ack[d]}, 32'h0);
        cyc[d] = 1'b0;
        rd_out = seen;
    endtask

    initial begin
        logic [31:0] rd;
        int          resp_seen;
        rst = 1'b1; cyc = '0; stb = '0; we = 1'b0; adr = '0; sel = '0; wdat = '0;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_val("rst_ack", ack[d], 0);
            check_val("rst_err", err[d], 0);
            check_val("rst_stall", stall[d], 0);
            check_val("rst_dat", dut_rdat(d), 0);
        end

        xfer(0, 1'b0, 16'h0012, 4'hF, 32'h0, rd);
        check_val("t1_read_zero", rd, 32'h0);

        xfer(0, 1'b1, 16'h0013, 4'hF, 32'hDEADBEEF, rd);
        xfer(0, 1'b1, 16'h0013, 4'h3, 32'h00001234, rd);
        xfer(0, 1'b0, 16'h0013, 4'hF, 32'h0, rd);
        check_val("t2_lane_merge", rd, 32'hDEAD1234);

        xfer(0, 1'b0, 16'h0018, 4'hF, 32'h0, rd);
        xfer(0, 1'b0, 16'h000F, 4'hF, 32'h0, rd);
        xfer(0, 1'b1, 16'h0018, 4'hF, 32'hA5A5A5A5, rd);
        for (int i = 0; i < NREG; i++) xfer(0, 1'b0, 16'(BASE + i), 4'hF, 32'h0, rd);

        xfer(1, 1'b1, 16'h0011, 4'hF, 32'hCAFEF00D, rd);
        xfer(1, 1'b0, 16'h0011, 4'hF, 32'h0, rd);
        check_val("t4_pipe_readback", rd, 32'hCAFEF00D);

        // Abort during WAIT: write must be dropped and nothing returned.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; adr = 16'h0014; sel = 4'hF; wdat = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        resp_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[1] || err[1]) resp_seen++;
        end
        $display("abort dut1 WR adr=0014 -> responses=%0d", resp_seen);
        check_val("t5_abort_noresp", resp_seen, 0);
        xfer(1, 1'b0, 16'h0014, 4'hF, 32'h0, rd);
        check_val("t5_abort_readback", rd, 32'h0);

        xfer(0, 1'b1, 16'h0012, 4'hF, 32'hFFFFFFFF, rd);
        xfer(0, 1'b0, 16'h0012, 4'hF, 32'h0, rd);
        check_val("t6_write_protect", rd, WP_ON ? 32'h0 : 32'hFFFFFFFF);

        for (int n = 0; n < 120; n++) begin
            xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), 16'($urandom_range(12, 27)),
                 4'($urandom_range(0, 15)), $urandom(), rd);
        end

        // Reset during WAIT aborts the transfer and clears every register.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; adr = 16'h0015; sel = 4'hF; wdat = 32'h55AA55AA;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; stb[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0; cyc[1] = 1'b0;
        clear_model();
        resp_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1] || err[1]) resp_seen++;
        end
        $display("reset-abort dut1 WR adr=0015 -> responses=%0d", resp_seen);
        check_val("rst_abort_noresp", resp_seen, 0);
        xfer(1, 1'b0, 16'h0015, 4'hF, 32'h0, rd);
        check_val("rst_clears_pipe", rd, 32'h0);
        xfer(0, 1'b0, 16'h0013, 4'hF, 32'h0, rd);
        check_val("rst_clears_classic", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
